// File: rtl/msrv32_imm_seq.sv
// Two-entry decode queue in front of the immediate generator.
// Ports: fetch valid/ready in, flush/stall control, head instr/imm_type/pc/illegal/count out.
module msrv32_imm_seq (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        instr_valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        instr_ready_out,
  input  logic        flush_in,
  input  logic        stall_in,
  output logic        dec_valid_out,
  output logic [24:0] instr_out,
  output logic [2:0]  imm_type_out,
  output logic [31:0] pc_out,
  output logic        illegal_out,
  output logic [1:0]  count_out
);

  localparam logic [2:0] IMM_R   = 3'b000;
  localparam logic [2:0] IMM_I   = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;

  typedef struct packed {
    logic [24:0] instr;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic        ill;
  } ent_t;

  ent_t       ent_q [2];
  ent_t       ent_d [2];
  logic [1:0] count_q, count_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       push, pop;
  ent_t       new_ent;

  logic [6:0] op;
  logic [2:0] f3;
  logic       op_u, op_j, op_i, op_s;
  logic       op_b, op_r, op_sys;

  // Enqueue-time classification
  always_comb begin
    op     = instr_in[6:0];
    f3     = instr_in[14:12];
    op_u   = (op == 7'b0110111) | (op == 7'b0010111);
    op_j   = (op == 7'b1101111);
    op_i   = (op == 7'b1100111) | (op == 7'b0000011)
           | (op == 7'b0010011) | (op == 7'b0001111);
    op_s   = (op == 7'b0100011);
    op_b   = (op == 7'b1100011);
    op_r   = (op == 7'b0110011);
    op_sys = (op == 7'b1110011);
    new_ent.instr = instr_in[31:7];
    new_ent.pc    = pc_in;
    new_ent.typ   = IMM_R;
    new_ent.ill   = 1'b0;
    unique case (1'b1)
      op_u:    new_ent.typ = IMM_U;
      op_j:    new_ent.typ = IMM_J;
      op_i:    new_ent.typ = IMM_I;
      op_s:    new_ent.typ = IMM_S;
      op_b:    new_ent.typ = IMM_B;
      op_r:    new_ent.typ = IMM_R;
      op_sys:  new_ent.typ = (f3 != 3'b000) ? IMM_CSR : IMM_I;
      default: new_ent.ill = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) new_ent.ill = 1'b1;
  end

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ent_q   <= ent_d;
    end
  end

  // Next state
  always_comb begin
    push    = instr_valid_in & instr_ready_out;
    pop     = dec_valid_out & ~stall_in;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ent_d   = ent_q;
    if (flush_in) begin
      count_d = 2'd0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end else begin
      if (push) begin
        ent_d[wr_q] = new_ent;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs; ready is held low while reset is asserted
  always_comb begin
    instr_ready_out = (count_q != 2'd2) & ~flush_in
                    & ms_riscv32_mp_rst_n_in;
    dec_valid_out   = (count_q != 2'd0);
    count_out       = count_q;
    instr_out       = '0;
    imm_type_out    = '0;
    pc_out          = '0;
    illegal_out     = 1'b0;
    if (dec_valid_out) begin
      instr_out    = ent_q[rd_q].instr;
      imm_type_out = ent_q[rd_q].typ;
      pc_out       = ent_q[rd_q].pc;
      illegal_out  = ent_q[rd_q].ill;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_seq.sv
// Self-checking bench for msrv32_imm_seq.
// Reference queue model plus directed and random stimulus.
module tb_msrv32_imm_seq;

  logic        clk;
  logic        rst_n;
  logic        instr_valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_ready_out;
  logic        flush_in;
  logic        stall_in;
  logic        dec_valid_out;
  logic [24:0] instr_out;
  logic [2:0]  imm_type_out;
  logic [31:0] pc_out;
  logic        illegal_out;
  logic [1:0]  count_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  msrv32_imm_seq dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .instr_valid_in         (instr_valid_in),
    .instr_in               (instr_in),
    .pc_in                  (pc_in),
    .instr_ready_out        (instr_ready_out),
    .flush_in               (flush_in),
    .stall_in               (stall_in),
    .dec_valid_out          (dec_valid_out),
    .instr_out              (instr_out),
    .imm_type_out           (imm_type_out),
    .pc_out                 (pc_out),
    .illegal_out            (illegal_out),
    .count_out              (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification: {illegal, imm_type}
  function automatic logic [3:0] ref_dec(logic [31:0] w);
    logic [2:0] t;
    logic       ill;
    t   = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17:                t = 3'd4;
      7'h6F:                       t = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h0F:  t = 3'd1;
      7'h23:                       t = 3'd2;
      7'h63:                       t = 3'd3;
      7'h33:                       t = 3'd0;
      7'h73:                       t = (w[14:12] != 0) ? 3'd6 : 3'd1;
      default:                     ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) ill = 1'b1;
    return {ill, t};
  endfunction

  task automatic check_outs();
    logic [3:0] d;
    chk("count", count_out, mq.size());
    chk("dec_valid", dec_valid_out, mq.size() != 0);
    if (mq.size() == 0) begin
      chk("instr_empty", instr_out, 0);
      chk("type_empty", imm_type_out, 0);
      chk("pc_empty", pc_out, 0);
      chk("ill_empty", illegal_out, 0);
    end else begin
      d = ref_dec(mq[0].instr);
      chk("instr", instr_out, mq[0].instr[31:7]);
      chk("type", imm_type_out, d[2:0]);
      chk("pc", pc_out, mq[0].pc);
      chk("ill", illegal_out, d[3]);
    end
  endtask

  // One clock: called at a negedge with inputs already driven
  task automatic step();
    bit   push, pop, rdy;
    ent_t e;
    #1;
    rdy = (mq.size() != 2) && !flush_in;
    chk("ready", instr_ready_out, rdy);
    push = instr_valid_in && rdy;
    pop  = (mq.size() != 0) && !stall_in;
    e.instr = instr_in;
    e.pc    = pc_in;
    @(posedge clk);
    if (flush_in) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(bit v, logic [31:0] w, logic [31:0] p,
                       bit f, bit s);
    instr_valid_in = v;
    instr_in       = w;
    pc_in          = p;
    flush_in       = f;
    stall_in       = s;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
            7'h0F, 7'h23, 7'h63, 7'h33, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 3) != 0)
      w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  logic [31:0] sweep_w [9];
  logic [3:0]  sweep_e [9];

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("rst_ready", instr_ready_out, 0);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", instr_ready_out, 1);
    @(negedge clk);

    // Single push, one-cycle latency
    drive(1, 32'h00500093, 32'h100, 0, 0);
    step();
    chk("t2_valid", dec_valid_out, 1);
    chk("t2_instr", instr_out, 25'h00A001);
    chk("t2_type", imm_type_out, 3'b001);
    chk("t2_pc", pc_out, 32'h100);
    drive(0, 0, 0, 0, 0);
    step();

    // Fill under stall; third is refused
    drive(1, 32'h00100013, 32'h200, 0, 1);
    step();
    drive(1, 32'h00200013, 32'h204, 0, 1);
    step();
    drive(1, 32'h00300013, 32'h208, 0, 1);
    #1;
    chk("t3_ready3", instr_ready_out, 0);
    @(negedge clk);
    step();
    chk("t3_count", count_out, 2);
    chk("t3_head", pc_out, 32'h200);
    drive(0, 0, 0, 0, 0);
    step();
    chk("t3_drain1", pc_out, 32'h204);
    step();
    chk("t3_drain2", dec_valid_out, 0);

    // Push and pop together at count 1
    drive(1, 32'h00400013, 32'h300, 0, 0);
    step();
    drive(1, 32'h00500013, 32'h304, 0, 0);
    step();
    chk("t4_count", count_out, 1);
    chk("t4_head", pc_out, 32'h304);
    drive(0, 0, 0, 0, 0);
    step();

    // Flush at FULL drops concurrent push
    drive(1, 32'h00600013, 32'h400, 0, 1);
    step();
    drive(1, 32'h00700013, 32'h404, 0, 1);
    step();
    drive(1, 32'h00800013, 32'h408, 1, 0);
    step();
    chk("t5_count", count_out, 0);
    chk("t5_valid", dec_valid_out, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("t5_absent", dec_valid_out, 0);

    // Decode sweep, model pinned against literals
    sweep_w = '{32'h30529073, 32'h00000073, 32'h0000006F,
                32'h00000063, 32'h00000023, 32'h00000037,
                32'h00000033, 32'h0000007F, 32'h00000010};
    sweep_e = '{4'b0110, 4'b0001, 4'b0101, 4'b0011, 4'b0010,
                4'b0100, 4'b0000, 4'b1000, 4'b1000};
    for (int i = 0; i < 9; i++) begin
      chk("model_dec", ref_dec(sweep_w[i]), sweep_e[i]);
      drive(1, sweep_w[i], 32'h500 + 4 * i, 0, 0);
      step();
      chk("sweep_dut", {illegal_out, imm_type_out}, sweep_e[i]);
    end
    drive(0, 0, 0, 0, 0);
    step();

    // Async reset while FULL
    drive(1, 32'h00900013, 32'h600, 0, 1);
    step();
    drive(1, 32'h00A00013, 32'h604, 0, 1);
    step();
    chk("t1_full", count_out, 2);
    drive(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("t1_ready", instr_ready_out, 0);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_rel_cnt", count_out, 0);
    chk("t1_rel_rdy", instr_ready_out, 1);
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
